// File: rtl/seg_pkg.sv
// Shared constants, state encoding and glyph lookup for the multiplexed
// 7-segment display driver.
package seg_pkg;

   localparam logic [6:0] GLYPH_0     = 7'h3F;
   localparam logic [6:0] GLYPH_1     = 7'h06;
   localparam logic [6:0] GLYPH_2     = 7'h5B;
   localparam logic [6:0] GLYPH_3     = 7'h4F;
   localparam logic [6:0] GLYPH_4     = 7'h66;
   localparam logic [6:0] GLYPH_5     = 7'h6D;
   localparam logic [6:0] GLYPH_6     = 7'h7D;
   localparam logic [6:0] GLYPH_7     = 7'h07;
   localparam logic [6:0] GLYPH_8     = 7'h7F;
   localparam logic [6:0] GLYPH_9     = 7'h6F;
   localparam logic [6:0] GLYPH_DASH  = 7'h40;
   localparam logic [6:0] GLYPH_BLANK = 7'h00;

   localparam int DP_BIT = 7;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CONV,
      ST_COMMIT
   } ctrl_state_e;

   // Active-high {g..a} pattern; non-decimal nibbles render blank.
   function automatic logic [6:0] bcd_glyph(input logic [3:0] nib);
      case (nib)
         4'd0:    return GLYPH_0;
         4'd1:    return GLYPH_1;
         4'd2:    return GLYPH_2;
         4'd3:    return GLYPH_3;
         4'd4:    return GLYPH_4;
         4'd5:    return GLYPH_5;
         4'd6:    return GLYPH_6;
         4'd7:    return GLYPH_7;
         4'd8:    return GLYPH_8;
         4'd9:    return GLYPH_9;
         default: return GLYPH_BLANK;
      endcase
   endfunction

   function automatic int unsigned pow10(input int n);
      int unsigned r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Valid/ready input channel carrying the binary value to be displayed.
interface seg_scan_display_if #(
   parameter int DATA_W = 14
);
   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);
endinterface

// File: rtl/bin2bcd_seq.sv
// Iterative add-3 double-dabble: one binary bit shifted in per cycle,
// DATA_W cycles after start; done flags the cycle of the final shift.
module bin2bcd_seq
   import seg_pkg::*;
#(
   parameter int DATA_W = 14,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     din,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(DATA_W + 1);

   logic [DATA_W-1:0] bin_q, bin_d;
   logic [BCD_W-1:0]  bcd_q, bcd_d;
   logic [BCD_W-1:0]  adj;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              busy_q, busy_d;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end

      bin_d  = bin_q;
      bcd_d  = bcd_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      if (start) begin
         bin_d  = din;
         bcd_d  = '0;
         cnt_d  = CNT_W'(DATA_W);
         busy_d = 1'b1;
      end else if (busy_q) begin
         bcd_d = {adj[BCD_W-2:0], bin_q[DATA_W-1]};
         bin_d = bin_q << 1;
         cnt_d = cnt_q - 1'b1;
         if (cnt_q == CNT_W'(1)) busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bin_q  <= '0;
         bcd_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         bin_q  <= bin_d;
         bcd_q  <= bcd_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign done = busy_q && (cnt_q == CNT_W'(1));
   assign bcd  = bcd_q;

endmodule

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment driver: handshake, BCD conversion, frame-aligned
// commit to the display register, and registered digit scan outputs.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int DIGITS      = 4,
   parameter int DATA_W      = 14,
   parameter int SCAN_CYC    = 100000,
   parameter int DP_POS      = 1,
   parameter bit LZ_BLANK    = 1'b1,
   parameter bit SEL_ACT_LOW = 1'b1,
   parameter bit SEG_ACT_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                rst,
   seg_scan_display_if.slave   bus,
   input  logic                hold,
   output logic [DIGITS-1:0]   sel_o,
   output logic [7:0]          seg_o,
   output logic                ovf
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int CNT_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SCAN_CYC - 1);
   localparam int unsigned      MAX_VAL  = pow10(DIGITS) - 1;

   ctrl_state_e       state_q, state_d;
   logic              din_ready_q, din_ready_d;
   logic              ovf_pend_q, ovf_pend_d;
   logic [BCD_W-1:0]  disp_bcd_q, disp_bcd_d;
   logic              disp_ovf_q, disp_ovf_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [DIGITS-1:0] sel_q, sel_d;
   logic [7:0]        seg_q, seg_d;

   logic              conv_start;
   logic              conv_done;
   logic [BCD_W-1:0]  conv_bcd;
   logic              frame_end;
   logic [IDX_W-1:0]  pos_idx;
   logic [3:0]        nib;
   logic              lead_zero;
   logic [7:0]        seg_act;

   assign conv_start    = bus.din_valid && din_ready_q;
   assign bus.din_ready = din_ready_q;
   assign frame_end     = (idx_q == LAST_IDX) && (cnt_q == LAST_CNT);

   bin2bcd_seq #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk   (clk),
      .rst   (rst),
      .start (conv_start),
      .din   (bus.din),
      .done  (conv_done),
      .bcd   (conv_bcd)
   );

   // The display register only changes on the frame wrap, so a frame never mixes values.
   always_comb begin
      state_d    = state_q;
      ovf_pend_d = ovf_pend_q;
      disp_bcd_d = disp_bcd_q;
      disp_ovf_d = disp_ovf_q;
      case (state_q)
         ST_IDLE: begin
            if (conv_start) begin
               state_d    = ST_CONV;
               ovf_pend_d = 32'(bus.din) > MAX_VAL;
            end
         end
         ST_CONV: begin
            if (conv_done) state_d = ST_COMMIT;
         end
         ST_COMMIT: begin
            if (frame_end && !hold) begin
               disp_bcd_d = conv_bcd;
               disp_ovf_d = ovf_pend_q;
               state_d    = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      din_ready_d = (state_d == ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         din_ready_q <= 1'b1;
         ovf_pend_q  <= 1'b0;
         disp_bcd_q  <= '0;
         disp_ovf_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         din_ready_q <= din_ready_d;
         ovf_pend_q  <= ovf_pend_d;
         disp_bcd_q  <= disp_bcd_d;
         disp_ovf_q  <= disp_ovf_d;
      end
   end

   always_comb begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
      if (cnt_q == LAST_CNT) begin
         cnt_d = '0;
         idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
      end
   end

   // Index 0 is the leftmost digit; pos_idx is the same digit counted from the LSD.
   always_comb begin
      pos_idx   = LAST_IDX - idx_q;
      nib       = '0;
      lead_zero = 1'b1;
      for (int j = 0; j < DIGITS; j++) begin
         if (j == int'(pos_idx)) nib = disp_bcd_q[4*j +: 4];
         if (j >= int'(pos_idx) && disp_bcd_q[4*j +: 4] != 4'd0) lead_zero = 1'b0;
      end

      seg_act = {1'b0, bcd_glyph(nib)};
      if (LZ_BLANK && lead_zero && int'(pos_idx) > DP_POS) seg_act = {1'b0, GLYPH_BLANK};
      if (int'(pos_idx) == DP_POS) seg_act[DP_BIT] = 1'b1;
      if (disp_ovf_q) seg_act = {1'b0, GLYPH_DASH};

      seg_d        = seg_act;
      sel_d        = '0;
      sel_d[idx_q] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
         sel_q <= '0;
         seg_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         idx_q <= idx_d;
         sel_q <= sel_d;
         seg_q <= seg_d;
      end
   end

   assign sel_o = sel_q ^ {DIGITS{SEL_ACT_LOW}};
   assign seg_o = seg_q ^ {8{SEG_ACT_LOW}};
   assign ovf   = disp_ovf_q;

endmodule
